// File: rtl/mc_control_fsm_pkg.sv
// mc_control_fsm_pkg: opcodes, state encoding, select codes and control bundle for the multicycle MIPS controller.
package mc_control_fsm_pkg;
    localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4, OP_J = 6'd2, OP_ADDI = 6'd8;
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11
    } state_e;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_SHL2 = 2'b11;
    localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;
    // FETCH out of DECODE doubles as the unsupported-opcode indication
    function automatic state_e decode_next(input logic [5:0] op);
        return op == OP_R ? EXEC :
               (op == OP_LW || op == OP_SW) ? MEMADR :
               op == OP_BEQ ? BRANCH :
               op == OP_J ? JUMP :
               op == OP_ADDI ? ADDI_EX : FETCH;
    endfunction
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: instruction/memory inputs and datapath control outputs of the main control unit.
interface mc_control_fsm_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             memReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             illegalOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] instrCount;
    modport master (
        input  opcode, memReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp, state, instrCount
    );
    modport slave (
        output opcode, memReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp, state, instrCount
    );
endinterface

// File: rtl/mc_control_outdec.sv
// mc_control_outdec: combinational decode of current state (plus memReady and reset) into datapath controls.
module mc_control_outdec
    import mc_control_fsm_pkg::*;
(
    input  state_e     st,
    input  logic       mr,
    input  logic       reset,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        case (st)
            FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.ir_write = mr;
                ctrl.pc_write = mr;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_SHL2;
                ctrl.illegal_op = decode_next(opcode) == FETCH;
            end
            MEMADR, ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDI_WB: ctrl.reg_write = 1'b1;
            default: ;
        endcase
        // reset silences every strobe and parks the selects at their FETCH values
        if (reset) begin
            ctrl = '0;
            ctrl.alu_src_b = SRCB_4;
        end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control FSM with memReady stalls and a retired-instruction counter.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);
    state_e           st, nxt;
    logic             mr, retire;
    logic [CNT_W-1:0] cnt;
    ctrl_t            c;

    assign mr = MEM_WAIT_EN ? bus.memReady : 1'b1;
    assign retire = (st inside {MEMWB, RWB, BRANCH, JUMP, ADDI_WB}) || (st == MEMWR && mr);

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:   nxt = mr ? DECODE : FETCH;
            DECODE:  nxt = decode_next(bus.opcode);
            MEMADR:  nxt = bus.opcode == OP_LW ? MEMRD : MEMWR;
            MEMRD:   nxt = mr ? MEMWB : MEMRD;
            MEMWR:   nxt = mr ? FETCH : MEMWR;
            EXEC:    nxt = RWB;
            ADDI_EX: nxt = ADDI_WB;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= FETCH;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    mc_control_outdec u_outdec (
        .st     (st),
        .mr     (mr),
        .reset  (reset),
        .opcode (bus.opcode),
        .ctrl   (c)
    );

    assign bus.PCWrite     = c.pc_write;
    assign bus.PCWriteCond = c.pc_write_cond;
    assign bus.IorD        = c.iord;
    assign bus.MemRead     = c.mem_read;
    assign bus.MemWrite    = c.mem_write;
    assign bus.IRWrite     = c.ir_write;
    assign bus.MemtoReg    = c.mem_to_reg;
    assign bus.RegDst      = c.reg_dst;
    assign bus.RegWrite    = c.reg_write;
    assign bus.ALUSrcA     = c.alu_src_a;
    assign bus.ALUSrcB     = c.alu_src_b;
    assign bus.ALUOp       = c.alu_op;
    assign bus.PCSource    = c.pc_source;
    assign bus.illegalOp   = c.illegal_op;
    assign bus.state       = st;
    assign bus.instrCount  = cnt;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: instruction-level driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(4)) bus ();
    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [3:0]  s;
        logic [16:0] v;
        logic [3:0]  c;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_m = 0;
    logic [16:0] act_vec;
    localparam logic [16:0] RST_VEC = {10'b0, 2'b01, 2'b00, 2'b00, 1'b0};

    assign act_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                      bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                      bus.PCSource, bus.illegalOp};

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8};
    endfunction

    // control word each state must present, straight from the state table
    function automatic logic [16:0] exp_out(input int s, input logic mr, input logic [5:0] op);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, il;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, il} = '0;
        {sb, ao, ps} = '0;
        case (s)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1: begin sb = 2'b11; il = !legal(op); end
            2, 10: begin sa = 1; sb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin sa = 1; ao = 2'b10; end
            7: begin rw = 1; rdst = 1; end
            8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9: begin pw = 1; ps = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, il};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic cycle(input int s, input logic [5:0] op, input logic mr);
        bus.opcode = op;
        bus.memReady = mr;
        q.push_back('{s: 4'(s), v: exp_out(s, mr, op), c: 4'(cnt_m)});
        @(posedge clk);
        #1;
    endtask

    // one instruction: fw fetch stalls, mw memory stalls
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        repeat (fw) cycle(0, 6'($urandom), 1'b0);
        cycle(0, 6'($urandom), 1'b1);
        cycle(1, op, rb());
        case (op)
            6'd0: begin cycle(6, op, rb()); cycle(7, op, rb()); end
            6'd35: begin
                cycle(2, op, rb());
                repeat (mw) cycle(3, op, 1'b0);
                cycle(3, op, 1'b1);
                cycle(4, op, rb());
            end
            6'd43: begin
                cycle(2, op, rb());
                repeat (mw) cycle(5, op, 1'b0);
                cycle(5, op, 1'b1);
            end
            6'd4: cycle(8, op, rb());
            6'd2: cycle(9, op, rb());
            6'd8: begin cycle(10, op, rb()); cycle(11, op, rb()); end
            default: ;
        endcase
        if (legal(op)) cnt_m = (cnt_m + 1) % 16;
    endtask

    task automatic run_random(input int n);
        logic [5:0] ops[8];
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd63, 6'd13};
        for (int i = 0; i < n; i++) begin
            run_instr($urandom_range(0, 9) == 0 ? 6'($urandom) : ops[$urandom_range(0, 7)],
                      $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("state", int'(bus.state), int'(e.s));
            check("ctrl", int'(act_vec), int'(e.v));
            check("count", int'(bus.instrCount), int'(e.c));
        end
    end

    initial begin
        bus.opcode = 6'd0;
        bus.memReady = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("por_state", int'(bus.state), 0);
        check("por_count", int'(bus.instrCount), 0);
        check("por_ctrl", int'(act_vec), int'(RST_VEC));
        @(posedge clk);
        #4 reset = 1'b0;
        @(posedge clk);
        #1;
        run_instr(6'd35, 0, 0);
        run_instr(6'd0, 0, 0);
        run_instr(6'd4, 0, 0);
        run_instr(6'd2, 0, 0);
        run_instr(6'd8, 1, 0);
        run_instr(6'd43, 0, 3);
        run_instr(6'd63, 0, 0);
        run_instr(6'd35, 2, 2);
        run_random(12);
        // async reset in the middle of a stalled MEMRD
        cycle(0, 6'd5, 1'b1);
        cycle(1, 6'd35, rb());
        cycle(2, 6'd35, rb());
        bus.memReady = 1'b0;
        check("pre_rst_state", int'(bus.state), 3);
        #3 reset = 1'b1;
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_count", int'(bus.instrCount), 0);
        check("rst_ctrl", int'(act_vec), int'(RST_VEC));
        cnt_m = 0;
        @(posedge clk);
        #4 reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_state", int'(bus.state), 0);
        for (int i = 0; i < 17; i++) run_instr(6'd2, 0, 0);
        run_instr(6'd63, 0, 0);
        run_random(80);
        cycle(0, 6'd0, 1'b0);
        repeat (2) @(posedge clk);
        check("drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
